// File: rtl/datapath_writeback_if.sv
// Writeback stage bus: EX_WB bundle, load return data, decode read ports,
// forwarding pair, flags, stall and retire count.
interface datapath_writeback_if;
  logic [79:0] EX_WB;
  logic        wb_valid;
  logic [15:0] i_ldst_rddata;
  logic        i_ldst_rddata_valid;
  logic [2:0]  rd_addr1;
  logic [2:0]  rd_addr2;
  logic [15:0] rd_data1;
  logic [15:0] rd_data2;
  logic [15:0] dataw;
  logic [2:0]  regw;
  logic        regw_valid;
  logic        Z;
  logic        N;
  logic        o_stall;
  logic [15:0] o_retired;

  modport master (
    output EX_WB, wb_valid,
    output i_ldst_rddata, i_ldst_rddata_valid,
    output rd_addr1, rd_addr2,
    input  rd_data1, rd_data2,
    input  dataw, regw, regw_valid,
    input  Z, N, o_stall, o_retired
  );

  modport slave (
    input  EX_WB, wb_valid,
    input  i_ldst_rddata, i_ldst_rddata_valid,
    input  rd_addr1, rd_addr2,
    output rd_data1, rd_data2,
    output dataw, regw, regw_valid,
    output Z, N, o_stall, o_retired
  );
endinterface

// File: rtl/datapath_writeback.sv
// Writeback stage: register file, Z/N flags, retire counter, load-wait stall.
// Optional WB_BYPASS_EN makes the read ports write-through.
module datapath_writeback #(
  parameter int NREGS = 8,
  parameter int DW    = 16
) (
  input logic clk,
  input logic reset,
  datapath_writeback_if.slave wb
);
  localparam int AW = $clog2(NREGS);

  typedef enum logic {RUN, LDWAIT} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] rf_q [NREGS];
  logic          z_q, n_q;
  logic [15:0]   ret_q;

  logic [15:0]   pc, alu, instr;
  logic [4:0]    op;
  logic [AW-1:0] rx;
  logic          is_alu_wr, is_ld, is_call, is_flag;
  logic          retire, stall;
  logic          wr_en;
  logic [AW-1:0] wr_idx;
  logic [DW-1:0] wr_data;
  logic          unused_ok;

  assign pc    = wb.EX_WB[79:64];
  assign alu   = wb.EX_WB[31:16];
  assign instr = wb.EX_WB[15:0];
  assign op    = instr[4:0];
  assign rx    = instr[7:5];

  assign unused_ok = ^{wb.EX_WB[63:32], instr[15:8]};

  always_comb begin
    is_alu_wr = 1'b0;
    is_ld     = 1'b0;
    is_call   = 1'b0;
    is_flag   = 1'b0;
    unique case (op)
      5'b00000: is_alu_wr = 1'b1;
      5'b00001: begin is_alu_wr = 1'b1; is_flag = 1'b1; end
      5'b00010: begin is_alu_wr = 1'b1; is_flag = 1'b1; end
      5'b00011: is_flag = 1'b1;
      5'b10000: is_alu_wr = 1'b1;
      5'b10001: begin is_alu_wr = 1'b1; is_flag = 1'b1; end
      5'b10010: begin is_alu_wr = 1'b1; is_flag = 1'b1; end
      5'b10011: is_flag = 1'b1;
      5'b10110: is_alu_wr = 1'b1;
      5'b00100: is_ld = 1'b1;
      5'b11100: is_call = 1'b1;
      5'b01100: is_call = 1'b1;
      default: ;
    endcase
  end

  // EX_WB is held by upstream during LDWAIT, so the live opcode is still ld
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    retire  = 1'b0;
    if (!reset) begin
      unique case (state_q)
        RUN: begin
          if (wb.wb_valid) begin
            if (is_ld && !wb.i_ldst_rddata_valid) begin
              state_d = LDWAIT;
              stall   = 1'b1;
            end else begin
              retire = 1'b1;
            end
          end
        end
        LDWAIT: begin
          stall = 1'b1;
          if (wb.wb_valid && wb.i_ldst_rddata_valid) begin
            stall   = 1'b0;
            retire  = 1'b1;
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    wr_en   = retire && (is_alu_wr || is_ld || is_call);
    wr_idx  = is_call ? AW'(NREGS - 1) : rx;
    wr_data = alu;
    if (is_ld) wr_data = wb.i_ldst_rddata;
    else if (is_call) wr_data = pc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      ret_q   <= '0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (wr_en) rf_q[wr_idx] <= wr_data;
      if (retire && is_flag) begin
        z_q <= (alu == '0);
        n_q <= alu[15];
      end
      if (retire) ret_q <= ret_q + 16'd1;
    end
  end

  assign wb.regw_valid = wr_en;
  assign wb.regw       = wr_en ? wr_idx : '0;
  assign wb.dataw      = wr_en ? wr_data : '0;
  assign wb.Z          = z_q;
  assign wb.N          = n_q;
  assign wb.o_stall    = stall;
  assign wb.o_retired  = ret_q;

`ifdef WB_BYPASS_EN
  assign wb.rd_data1 = (wr_en && wr_idx == wb.rd_addr1)
                       ? wr_data : rf_q[wb.rd_addr1];
  assign wb.rd_data2 = (wr_en && wr_idx == wb.rd_addr2)
                       ? wr_data : rf_q[wb.rd_addr2];
`else
  assign wb.rd_data1 = rf_q[wb.rd_addr1];
  assign wb.rd_data2 = rf_q[wb.rd_addr2];
`endif
endmodule

// File: tb/tb_datapath_writeback.sv
// Bench for datapath_writeback: spec-level model plus directed literals.
// Honours WB_BYPASS_EN when it is defined for the build.
module tb_datapath_writeback;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  datapath_writeback_if bus ();

  datapath_writeback dut (
    .clk  (clk),
    .reset(reset),
    .wb   (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  logic [15:0] m_rf [8];
  logic        m_z, m_n, m_wait;
  logic [15:0] m_ret;

  logic [4:0]  e_op;
  logic [2:0]  e_rx;
  logic        e_ld, e_call, e_alu, e_flag;
  logic        e_ret, e_stall, e_wv;
  logic [2:0]  e_rw;
  logic [15:0] e_dw, e_rd1, e_rd2;

  function automatic logic [15:0] mk(input logic [4:0] op,
                                     input logic [2:0] rx);
    return {8'h00, rx, op};
  endfunction

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h @%0t", nm, act, exp, $time);
    end
  endtask

  // expected outputs straight from the instruction rules
  always_comb begin
    e_op   = bus.EX_WB[4:0];
    e_rx   = bus.EX_WB[7:5];
    e_ld   = (e_op == 5'b00100);
    e_call = (e_op == 5'b11100) || (e_op == 5'b01100);
    e_alu  = e_op inside {5'b00000, 5'b00001, 5'b00010, 5'b10000,
                          5'b10001, 5'b10010, 5'b10110};
    e_flag = e_op inside {5'b00001, 5'b00010, 5'b00011,
                          5'b10001, 5'b10010, 5'b10011};
    e_ret  = !reset && bus.wb_valid &&
             !(e_ld && !bus.i_ldst_rddata_valid);
    e_stall = !reset && ((m_wait && !e_ret) ||
              (bus.wb_valid && e_ld && !bus.i_ldst_rddata_valid));
    e_wv = e_ret && (e_alu || e_ld || e_call);
    e_rw = 3'd0;
    e_dw = 16'h0000;
    if (e_wv) begin
      e_rw = e_call ? 3'd7 : e_rx;
      e_dw = e_ld ? bus.i_ldst_rddata :
             e_call ? bus.EX_WB[79:64] : bus.EX_WB[31:16];
    end
    e_rd1 = m_rf[bus.rd_addr1];
    e_rd2 = m_rf[bus.rd_addr2];
`ifdef WB_BYPASS_EN
    if (e_wv && e_rw == bus.rd_addr1) e_rd1 = e_dw;
    if (e_wv && e_rw == bus.rd_addr2) e_rd2 = e_dw;
`endif
  end

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) m_rf[i] <= 16'h0000;
      m_z    <= 1'b0;
      m_n    <= 1'b0;
      m_ret  <= 16'h0000;
      m_wait <= 1'b0;
    end else begin
      if (e_wv) m_rf[e_rw] <= e_dw;
      if (e_ret && e_flag) begin
        m_z <= (bus.EX_WB[31:16] == 16'h0000);
        m_n <= bus.EX_WB[31];
      end
      if (e_ret) m_ret <= m_ret + 16'd1;
      if (bus.wb_valid) m_wait <= e_ld && !bus.i_ldst_rddata_valid;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", {15'd0, bus.o_stall}, {15'd0, e_stall});
      chk("regw_valid", {15'd0, bus.regw_valid}, {15'd0, e_wv});
      chk("regw", {13'd0, bus.regw}, {13'd0, e_rw});
      chk("dataw", bus.dataw, e_dw);
      chk("Z", {15'd0, bus.Z}, {15'd0, m_z});
      chk("N", {15'd0, bus.N}, {15'd0, m_n});
      chk("retired", bus.o_retired, m_ret);
      chk("rd_data1", bus.rd_data1, e_rd1);
      chk("rd_data2", bus.rd_data2, e_rd2);
    end
  end

  task automatic put(input logic [15:0] pc, input logic [15:0] alu,
                     input logic [15:0] ins, input logic v,
                     input logic [15:0] rd, input logic rv);
    bus.EX_WB               = {pc, 16'h1111, 16'h2222, alu, ins};
    bus.wb_valid            = v;
    bus.i_ldst_rddata       = rd;
    bus.i_ldst_rddata_valid = rv;
  endtask

  task automatic idle();
    put(16'h0, 16'h0, mk(5'b00111, 3'd0), 1'b0, 16'h0, 1'b0);
  endtask

  task automatic edge_();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic one(input logic [15:0] pc, input logic [15:0] alu,
                     input logic [15:0] ins);
    put(pc, alu, ins, 1'b1, 16'h0, 1'b0);
    edge_();
  endtask

  int stalls;

  initial begin
    reset = 1'b1;
    bus.rd_addr1 = 3'd0;
    bus.rd_addr2 = 3'd0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;
    chk("reset_ret", bus.o_retired, 16'h0000);
    chk("reset_Z", {15'd0, bus.Z}, 16'h0000);
    chk("reset_rd", bus.rd_data1, 16'h0000);

    // mvi r3,#-5
    bus.rd_addr1 = 3'd3;
    put(16'h0010, 16'hFFFB, mk(5'b10000, 3'd3), 1'b1, 16'h0, 1'b0);
    @(negedge clk);
    chk("mvi_regw", {13'd0, bus.regw}, 16'd3);
    chk("mvi_wv", {15'd0, bus.regw_valid}, 16'd1);
    edge_();
    chk("mvi_r3", bus.rd_data1, 16'hFFFB);
    chk("mvi_N", {15'd0, bus.N}, 16'd0);
    chk("mvi_ret", bus.o_retired, 16'd1);

    // seed r1, then sub r1 -> zero, then cmpi -> negative
    one(16'h0011, 16'h5555, mk(5'b10000, 3'd1));
    bus.rd_addr1 = 3'd1;
    one(16'h0012, 16'h0000, mk(5'b00010, 3'd1));
    chk("sub_r1", bus.rd_data1, 16'h0000);
    chk("sub_Z", {15'd0, bus.Z}, 16'd1);
    chk("sub_N", {15'd0, bus.N}, 16'd0);
    put(16'h0013, 16'h8000, mk(5'b10011, 3'd1), 1'b1, 16'h0, 1'b0);
    @(negedge clk);
    chk("cmpi_wv", {15'd0, bus.regw_valid}, 16'd0);
    edge_();
    chk("cmpi_Z", {15'd0, bus.Z}, 16'd0);
    chk("cmpi_N", {15'd0, bus.N}, 16'd1);
    chk("cmpi_r1", bus.rd_data1, 16'h0000);

    // ld r4 with three cycles of missing data
    bus.rd_addr1 = 3'd4;
    stalls = 0;
    put(16'h0014, 16'h0000, mk(5'b00100, 3'd4), 1'b1, 16'h0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin
        bus.i_ldst_rddata       = 16'h1234;
        bus.i_ldst_rddata_valid = 1'b1;
      end
      @(negedge clk);
      if (bus.o_stall) stalls++;
      @(posedge clk);
      #1;
    end
    idle();
    chk("ld_stalls", 16'(stalls), 16'd3);
    chk("ld_r4", bus.rd_data1, 16'h1234);
    chk("ld_ret", bus.o_retired, 16'd5);

    // call, st, jz
    bus.rd_addr1 = 3'd7;
    one(16'h0042, 16'h0099, mk(5'b11100, 3'd2));
    chk("call_r7", bus.rd_data1, 16'h0042);
    chk("call_N", {15'd0, bus.N}, 16'd1);
    put(16'h0043, 16'h0077, mk(5'b00101, 3'd2), 1'b1, 16'h0, 1'b0);
    @(negedge clk);
    chk("st_wv", {15'd0, bus.regw_valid}, 16'd0);
    edge_();
    one(16'h0044, 16'h0066, mk(5'b01001, 3'd3));
    chk("jz_ret", bus.o_retired, 16'd8);

    // ld with data ready immediately, then a bubble
    bus.rd_addr2 = 3'd2;
    put(16'h0045, 16'h0000, mk(5'b00100, 3'd2), 1'b1, 16'hABCD, 1'b1);
    edge_();
    chk("ldnow_r2", bus.rd_data2, 16'hABCD);
    edge_();

    // addi r5 while decode reads r5
    bus.rd_addr1 = 3'd5;
    put(16'h0046, 16'h0007, mk(5'b10001, 3'd5), 1'b1, 16'h0, 1'b0);
    @(negedge clk);
`ifdef WB_BYPASS_EN
    chk("bypass_rd1", bus.rd_data1, 16'h0007);
`else
    chk("nobypass_rd1", bus.rd_data1, 16'h0000);
`endif
    edge_();
    chk("addi_r5", bus.rd_data1, 16'h0007);

    // retire counter wrap
    for (int i = 0; i < 65526; i++) begin
      put(16'h0100, 16'(i), mk(5'b00000, 3'd0), 1'b1, 16'h0, 1'b0);
      @(posedge clk);
      #1;
    end
    idle();
    chk("wrap_ret", bus.o_retired, 16'h0000);

    // reset while waiting on a load
    put(16'h0200, 16'h0000, mk(5'b00100, 3'd6), 1'b1, 16'h0, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("ldwait_stall", {15'd0, bus.o_stall}, 16'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.wb_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.i_ldst_rddata       = 16'hFFFF;
    bus.i_ldst_rddata_valid = 1'b1;
    @(negedge clk);
    chk("rst_stall", {15'd0, bus.o_stall}, 16'd0);
    chk("rst_wv", {15'd0, bus.regw_valid}, 16'd0);
    edge_();
    for (int r = 0; r < 8; r++) begin
      bus.rd_addr1 = 3'(r);
      #1;
      chk("rst_reg", bus.rd_data1, 16'h0000);
    end
    chk("rst_ret", bus.o_retired, 16'h0000);
    @(negedge clk);
    chk("rst_stall2", {15'd0, bus.o_stall}, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
